// File: rtl/fft_pkg.sv
// Shared constants, state encoding and sample conversion for the FFT input feeder.
package fft_pkg;

    localparam int         FFT_LEN      = 8192;
    localparam int         FFT_LEN_LOG2 = 13;
    localparam logic [7:0] CFG_FWD      = 8'd1;

    typedef enum logic {
        S_CFG = 1'b0,
        S_RUN = 1'b1
    } feed_state_t;

    // Zero-extended average minus the mid-scale code gives the signed real part.
    function automatic logic signed [15:0] to_signed16(input logic [15:0] avg,
                                                       input logic [15:0] offset);
        return $signed(avg) - $signed(offset);
    endfunction

endpackage

// File: rtl/fft_feed_fifo.sv
// Synchronous first-word-fall-through FIFO with synchronous clear; head is valid whenever !o_empty.
module fft_feed_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic             fft_clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    import fft_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr_en;
    logic             w_rd_en;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

    // A pop in the same cycle frees the slot, so a write to a full FIFO is still taken.
    assign w_wr_en = i_wr && (!o_full || i_rd);
    assign w_rd_en = i_rd && !o_empty;

    always_ff @(posedge fft_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge fft_clk) begin
        if (w_wr_en && !i_clr) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/fft_frame_feeder.sv
// Decimates/averages ADC samples, removes DC and streams framed complex beats into xfft_0.
//   state | meaning
//   S_CFG | config word offered on s_axis_config until accepted; data output held off
//   S_RUN | frames streamed back to back from the elastic FIFO
module fft_frame_feeder #(
    parameter int         FFT_LEN    = fft_pkg::FFT_LEN,
    parameter int         DEC        = 8,
    parameter int         AD_W       = 10,
    parameter int         DC_OFFSET  = 512,
    parameter logic [7:0] CFG_WORD   = fft_pkg::CFG_FWD,
    parameter int         FIFO_DEPTH = 16
) (
    input  logic            fft_clk,
    input  logic            rst_n,
    input  logic [AD_W-1:0] ad_data,
    input  logic            ad_valid,
    input  logic            restart,
    output logic [7:0]      cfg_tdata,
    output logic            cfg_tvalid,
    input  logic            cfg_tready,
    output logic [31:0]     s_tdata,
    output logic            s_tvalid,
    output logic            s_tlast,
    input  logic            s_tready,
    output logic            frame_done,
    output logic            overflow
);
    import fft_pkg::*;

    localparam int                DEC_LOG2  = $clog2(DEC);
    localparam int                ACC_W     = AD_W + DEC_LOG2;
    localparam int                BEAT_W    = $clog2(FFT_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FFT_LEN - 1);

    feed_state_t         r_state;
    feed_state_t         w_state_nxt;
    logic                r_cfg_tvalid;
    logic [DEC_LOG2-1:0] r_phase;
    logic [ACC_W-1:0]    r_acc;
    logic [15:0]         r_dec_data;
    logic                r_dec_vld;
    logic [BEAT_W-1:0]   r_beat;
    logic                r_frame_done;
    logic                r_overflow;

    logic [ACC_W-1:0]    w_sum;
    logic [AD_W-1:0]     w_avg;
    logic                w_cfg_hs;
    logic                w_run;
    logic                w_hs;
    logic                w_wr;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [15:0]         w_head;

    assign w_sum = r_acc + ACC_W'(ad_data);
    assign w_avg = AD_W'(w_sum >> DEC_LOG2);

    always_ff @(posedge fft_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase    <= '0;
            r_acc      <= '0;
            r_dec_data <= '0;
            r_dec_vld  <= 1'b0;
        end else if (restart) begin
            r_phase    <= '0;
            r_acc      <= '0;
            r_dec_vld  <= 1'b0;
        end else begin
            r_dec_vld <= 1'b0;
            if (ad_valid) begin
                if (r_phase == DEC_LOG2'(DEC - 1)) begin
                    r_phase    <= '0;
                    r_acc      <= '0;
                    r_dec_vld  <= 1'b1;
                    r_dec_data <= to_signed16(16'(w_avg), 16'(DC_OFFSET));
                end else begin
                    r_phase <= r_phase + DEC_LOG2'(1);
                    r_acc   <= w_sum;
                end
            end
        end
    end

    // cfg_tvalid is registered so it stays low while reset is asserted.
    always_ff @(posedge fft_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_CFG;
            r_cfg_tvalid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cfg_tvalid <= (w_state_nxt == S_CFG);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        case (r_state)
            S_CFG: if (w_cfg_hs) w_state_nxt = S_RUN;
            S_RUN: w_run = 1'b1;
            default: w_state_nxt = S_CFG;
        endcase
        if (restart) w_state_nxt = S_CFG;
    end

    assign w_cfg_hs   = r_cfg_tvalid && cfg_tready;
    assign cfg_tvalid = r_cfg_tvalid;
    assign cfg_tdata  = CFG_WORD;

    assign s_tvalid = !w_fifo_empty && w_run;
    assign s_tlast  = s_tvalid && (r_beat == LAST_BEAT);
    assign s_tdata  = s_tvalid ? {16'h0000, w_head} : 32'h0;
    assign w_hs     = s_tvalid && s_tready;
    assign w_wr     = r_dec_vld && w_run && !restart;

    fft_feed_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .fft_clk (fft_clk),
        .rst_n   (rst_n),
        .i_clr   (restart),
        .i_wr    (w_wr),
        .i_wdata (r_dec_data),
        .i_rd    (w_hs),
        .o_rdata (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Dropped samples never shorten a frame: the beat counter only follows transfers.
    always_ff @(posedge fft_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat       <= '0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else if (restart) begin
            r_beat       <= '0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_frame_done <= w_hs && (r_beat == LAST_BEAT);
            if (w_hs) r_beat <= (r_beat == LAST_BEAT) ? '0 : r_beat + BEAT_W'(1);
            if (w_wr && w_fifo_full && !w_hs) r_overflow <= 1'b1;
        end
    end

    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Directed bench for fft_frame_feeder with a short frame length; expected beats are queued
// as ADC samples are driven and compared as the feeder transfers them.
module tb_fft_frame_feeder;

    localparam int TB_LEN = 32;
    localparam int TB_DEC = 8;

    logic        fft_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  ad_data = '0;
    logic        ad_valid = 1'b0;
    logic        restart = 1'b0;
    logic [7:0]  cfg_tdata;
    logic        cfg_tvalid;
    logic        cfg_tready = 1'b0;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready = 1'b1;
    logic        frame_done;
    logic        overflow;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] sb_q[$];
    int          m_beat = 0;
    logic        m_fd_prev = 1'b0;
    int          m_frames = 0;
    int          m_fd_seen = 0;
    int          cfg_hs = 0;
    int          m_acc = 0;
    int          m_ph = 0;
    bit          m_run = 1'b0;

    always #5 fft_clk = ~fft_clk;

    fft_frame_feeder #(
        .FFT_LEN (TB_LEN)
    ) dut (
        .fft_clk    (fft_clk),
        .rst_n      (rst_n),
        .ad_data    (ad_data),
        .ad_valid   (ad_valid),
        .restart    (restart),
        .cfg_tdata  (cfg_tdata),
        .cfg_tvalid (cfg_tvalid),
        .cfg_tready (cfg_tready),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tlast    (s_tlast),
        .s_tready   (s_tready),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_real(input int sum);
        int avg;
        avg = sum / TB_DEC;
        return 16'(avg - 512);
    endfunction

    task automatic step(input logic v, input logic [9:0] d);
        ad_valid = v;
        ad_data  = d;
        @(posedge fft_clk);
        #1;
        ad_valid = 1'b0;
        if (v) begin
            m_acc += int'(d);
            m_ph++;
            if (m_ph == TB_DEC) begin
                if (m_run) sb_q.push_back(exp_real(m_acc));
                m_acc = 0;
                m_ph  = 0;
            end
        end
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        step(1'b0, 10'd0);
        restart = 1'b0;
        m_acc = 0;
        m_ph  = 0;
        m_run = 1'b0;
    endtask

    // Monitor: inputs settle after the rising edge, so the falling edge sees the upcoming transfer.
    always @(negedge fft_clk) begin
        if (rst_n) begin
            check("frame_done", {31'b0, frame_done}, {31'b0, m_fd_prev});
            if (frame_done) m_fd_seen++;
            if (cfg_tvalid && cfg_tready) cfg_hs++;
            m_fd_prev = 1'b0;
            if (s_tvalid && s_tready) begin
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $error("FAIL sb_underflow: observed beat %0h expected none", s_tdata);
                end else begin
                    check("s_tdata", s_tdata, {16'h0000, sb_q.pop_front()});
                end
                check("s_tlast", {31'b0, s_tlast}, {31'b0, (m_beat == TB_LEN - 1)});
                if (m_beat == TB_LEN - 1) begin
                    m_beat = 0;
                    if (!restart) begin
                        m_fd_prev = 1'b1;
                        m_frames++;
                    end
                end else begin
                    m_beat++;
                end
            end
            if (restart) begin
                m_beat = 0;
                sb_q.delete();
            end
        end
    end

    initial begin
        int          frames0;
        bit          seen;
        bit          hit;
        logic [31:0] held;
        logic        held_last;

        repeat (2) @(negedge fft_clk);
        check("rst_cfg_tvalid", {31'b0, cfg_tvalid}, 32'd0);
        check("rst_s_tvalid", {31'b0, s_tvalid}, 32'd0);
        check("rst_s_tlast", {31'b0, s_tlast}, 32'd0);
        check("rst_frame_done", {31'b0, frame_done}, 32'd0);
        check("rst_overflow", {31'b0, overflow}, 32'd0);
        check("rst_cfg_tdata", {24'b0, cfg_tdata}, 32'd1);
        check("rst_s_tdata", s_tdata, 32'd0);

        @(posedge fft_clk);
        #1 rst_n = 1'b1;
        repeat (5) begin
            @(posedge fft_clk);
            #1;
            check("cfg_wait_tvalid", {31'b0, cfg_tvalid}, 32'd1);
            check("cfg_wait_tdata", {24'b0, cfg_tdata}, 32'd1);
            check("cfg_wait_s_tvalid", {31'b0, s_tvalid}, 32'd0);
        end
        cfg_tready = 1'b1;
        step(1'b0, 10'd0);
        cfg_tready = 1'b0;
        m_run = 1'b1;
        check("cfg_after_hs", {31'b0, cfg_tvalid}, 32'd0);

        // Averages: ramp 0..7 -> -509, full scale -> 511, then a random block.
        for (int i = 0; i < 8; i++) step(1'b1, 10'(i));
        repeat (8) step(1'b1, 10'd1023);
        for (int i = 0; i < 8; i++) step(1'b1, 10'($urandom_range(0, 1023)));
        repeat (4) step(1'b0, 10'd0);
        check("sb_drained", sb_q.size(), 32'd0);

        frames0 = m_frames;
        for (int c = 0; c < 3000 && m_frames < frames0 + 2; c++) step(1'b1, 10'd600);
        check("two_frames", m_frames, frames0 + 2);

        for (int c = 0; c < 1000 && m_beat < 10; c++) step(1'b1, 10'd600);
        s_tready = 1'b0;
        seen = 1'b0;
        held = '0;
        held_last = 1'b0;
        for (int c = 0; c < 160; c++) begin
            step(1'b1, 10'd600);
            if (seen) begin
                check("stall_tvalid", {31'b0, s_tvalid}, 32'd1);
                check("stall_tdata", s_tdata, held);
                check("stall_tlast", {31'b0, s_tlast}, {31'b0, held_last});
            end else if (s_tvalid) begin
                seen = 1'b1;
                held = s_tdata;
                held_last = s_tlast;
            end
            if (c == 49) check("ovf_early", {31'b0, overflow}, 32'd0);
        end
        check("stall_head", held, 32'h0000_0058);
        check("ovf_set", {31'b0, overflow}, 32'd1);
        s_tready = 1'b1;
        frames0 = m_frames;
        for (int c = 0; c < 2000 && m_frames < frames0 + 1; c++) step(1'b1, 10'd600);
        check("stall_frame", m_frames, frames0 + 1);
        check("ovf_sticky", {31'b0, overflow}, 32'd1);

        for (int c = 0; c < 1000 && m_beat != 12; c++) step(1'b1, 10'd600);
        check("mid_frame_beat", m_beat, 32'd12);
        pulse_restart();
        check("rs_s_tvalid", {31'b0, s_tvalid}, 32'd0);
        check("rs_cfg_tvalid", {31'b0, cfg_tvalid}, 32'd1);
        check("rs_overflow", {31'b0, overflow}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            step(1'b1, 10'd600);
            check("cfg_hold_tvalid", {31'b0, cfg_tvalid}, 32'd1);
            check("cfg_no_data", {31'b0, s_tvalid}, 32'd0);
        end
        repeat (3) step(1'b0, 10'd0);
        check("cfg_discard", {31'b0, s_tvalid}, 32'd0);
        pulse_restart();
        check("rs_in_cfg_tvalid", {31'b0, cfg_tvalid}, 32'd1);
        check("cfg_hs_once", cfg_hs, 32'd1);
        cfg_tready = 1'b1;
        step(1'b0, 10'd0);
        cfg_tready = 1'b0;
        m_run = 1'b1;
        repeat (3) begin
            step(1'b0, 10'd0);
            check("cfg_resent_done", {31'b0, cfg_tvalid}, 32'd0);
        end
        check("cfg_hs_twice", cfg_hs, 32'd2);

        frames0 = m_frames;
        for (int c = 0; c < 6000 && m_frames < frames0 + 1; c++) begin
            s_tready = ($urandom_range(0, 3) != 0);
            step(1'b1, 10'($urandom_range(0, 1023)));
        end
        s_tready = 1'b1;
        check("restart_frame", m_frames, frames0 + 1);
        check("ovf_clear_run", {31'b0, overflow}, 32'd0);

        hit = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            step(1'b1, 10'd600);
            if (s_tvalid && s_tlast) begin
                hit = 1'b1;
                break;
            end
        end
        check("tlast_reached", {31'b0, hit}, 32'd1);
        frames0 = m_frames;
        pulse_restart();
        check("rs_tlast_state", {31'b0, cfg_tvalid}, 32'd1);
        check("rs_tlast_s_tvalid", {31'b0, s_tvalid}, 32'd0);
        check("rs_tlast_no_done", {31'b0, frame_done}, 32'd0);
        repeat (3) step(1'b0, 10'd0);
        check("rs_tlast_frames", m_frames, frames0);
        check("frame_done_count", m_fd_seen, m_frames);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
